instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RV32 instruction encoder and program loader: accepts field-level instruction commands over a valid/ready handshake, packs them into 32-bit machine words for the R/I/Load/S/B formats (plus the CNN custom opcode) and writes them to consecutive instruction-memory words. It sits between the host/command bus and the core's instruction memory write port. It produces exactly the encodings the core's main decoder consumes.

## Interface
- DEPTH, 4: command FIFO entries (power of two, ≥2)
- ADDR_W, 10: instruction-memory word-address width
- BASE_ADDR, 0: first word address written after `start`

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin load session; honoured only in IDLE
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready at clk edge
- cmd_fmt  in  3  0 R-ALU(0110011), 1 I-ALU(0010011), 2 LOAD(0000011), 3 STORE(0100011), 4 BRANCH(1100011), 5 CUSTOM(0101011)
- cmd_rd, cmd_rs1, cmd_rs2  in  5 each  register fields
- cmd_funct3  in  3;  cmd_funct7  in  7
- cmd_imm  in  13  two's-complement immediate; I/S use [11:0], B uses [12:1]
- cmd_last  in  1  final command of session
- imem_we  out  1  one-cycle write strobe per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky error; cleared by accepted `start`

## Operation
- FSM IDLE → RUN (on start; addr←BASE_ADDR, err←0) → FLUSH (on accepting cmd_last) → DONE (FIFO empty, last word written) → IDLE (next cycle).
- cmd_ready = (state==RUN) & !full; 0 in IDLE/FLUSH/DONE. start outside IDLE ignored.
- Push and pop in the same cycle allowed; count unchanged.
- Encoding (fields from FIFO head): R/CUSTOM {f7,rs2,rs1,f3,rd,op}; I/LOAD {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}. Unused fields ignored.
- Illegal fmt (6, 7, or 5 when custom disabled): entry popped, no write, no address increment, err←1.
- Address increments by 1 after each write; write at 2^ADDR_W−1 wraps next address to 0 and sets err.
- Reset: state IDLE, FIFO empty, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, cmd_ready 0, busy 0, done 0, err 0. Reset mid-session discards FIFO contents; no further writes.

## Timing
- Handshake at edge k into empty FIFO → imem_we/addr/wdata valid in cycle after edge k+1 (latency 2); all imem_* registered.
- Throughput one word per cycle sustained.
- done asserts the cycle after the final imem_we; busy deasserts the cycle after done.
- cmd_last accepted with FIFO non-empty: remaining entries drain in order before done.

## Configuration
- `INSTR_ENC_CUSTOM_EN` defined: fmt 5 encodes opcode 0101011 in R format. Undefined: fmt 5 is illegal (err, dropped); no custom-opcode logic synthesised.

## Structure
- Package `rv_enc_pkg`: opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_CUSTOM), fmt encoding constants, FSM state type.
- Sub-module `sync_fifo` (DEPTH, width = packed command fields); encoder/FSM/address counter in top.

## Test plan
- start; add x3,x1,x2 (fmt0,rd3,rs1 1,rs2 2,f3 0,f7 0,last) → one write addr 0, data 0x002081B3, done pulse.
- addi x1,x0,5 then lw x5,16(x1) back-to-back → 0x00500093 @0, 0x0100A283 @1 on consecutive cycles.
- sw x2,8(x1) → 0x0020A423; beq x1,x2,imm=−4 → 0xFE208EE3.
- Fill FIFO with imem path stalled by continuous push: cmd_ready drops at DEPTH entries, no command lost, order preserved.
- fmt 7 mid-stream → err=1, no write, next valid word at unchanged address; fmt 5 → 0x...2B word only with INSTR_ENC_CUSTOM_EN.
- ADDR_W=2, 5 commands → addresses 0,1,2,3,0 and err=1; rst low mid-session → all outputs at reset values immediately.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv_enc_pkg
// Brief  : Opcode, command-format and FSM definitions for instr_encoder
// Rev    : 1.0  initial release
// ============================================================================
package rv_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_CUSTOM = 7'b0101011;

    localparam logic [2:0] FMT_R      = 3'd0;
    localparam logic [2:0] FMT_I      = 3'd1;
    localparam logic [2:0] FMT_LOAD   = 3'd2;
    localparam logic [2:0] FMT_STORE  = 3'd3;
    localparam logic [2:0] FMT_BRANCH = 3'd4;
    localparam logic [2:0] FMT_CUSTOM = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One FIFO entry: every field the encoder may need, cmd_last excluded
    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [12:0] imm;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_if
// Brief  : Command handshake and instruction-memory write bus
// Rev    : 1.0  initial release
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_fmt;
    logic [4:0]        cmd_rd;
    logic [4:0]        cmd_rs1;
    logic [4:0]        cmd_rs2;
    logic [2:0]        cmd_funct3;
    logic [6:0]        cmd_funct7;
    logic [12:0]       cmd_imm;
    logic              cmd_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output cmd_valid, cmd_fmt, cmd_rd, cmd_rs1, cmd_rs2,
               cmd_funct3, cmd_funct7, cmd_imm, cmd_last,
        input  cmd_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_fmt, cmd_rd, cmd_rs1, cmd_rs2,
               cmd_funct3, cmd_funct7, cmd_imm, cmd_last,
        output cmd_ready, imem_we, imem_addr, imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO, DEPTH a power of two, simultaneous push/pop
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   cnt_q;

    // Storage carries no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder
// Brief  : RV32 field-level encoder and program loader; fmt 5 (CUSTOM) is
//          legal only when INSTR_ENC_CUSTOM_EN is defined
// Rev    : 1.0  initial release
// ============================================================================
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    instr_encoder_if.slave    bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    cmd_t              push_cmd, head;
    logic              push, pop, full, empty;
    logic              enc_legal;
    logic [31:0]       enc_word;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              err_q;

    assign push_cmd.fmt    = bus.cmd_fmt;
    assign push_cmd.rd     = bus.cmd_rd;
    assign push_cmd.rs1    = bus.cmd_rs1;
    assign push_cmd.rs2    = bus.cmd_rs2;
    assign push_cmd.funct3 = bus.cmd_funct3;
    assign push_cmd.funct7 = bus.cmd_funct7;
    assign push_cmd.imm    = bus.cmd_imm;

    assign bus.cmd_ready = (state_q == ST_RUN) && !full;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = !empty && ((state_q == ST_RUN) || (state_q == ST_FLUSH));

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_cmd),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (head.fmt)
            FMT_R:      enc_word = {head.funct7, head.rs2, head.rs1, head.funct3, head.rd, OP_R};
            FMT_I:      enc_word = {head.imm[11:0], head.rs1, head.funct3, head.rd, OP_I};
            FMT_LOAD:   enc_word = {head.imm[11:0], head.rs1, head.funct3, head.rd, OP_LOAD};
            FMT_STORE:  enc_word = {head.imm[11:5], head.rs2, head.rs1, head.funct3,
                                    head.imm[4:0], OP_STORE};
            FMT_BRANCH: enc_word = {head.imm[12], head.imm[10:5], head.rs2, head.rs1, head.funct3,
                                    head.imm[4:1], head.imm[11], OP_BRANCH};
`ifdef INSTR_ENC_CUSTOM_EN
            FMT_CUSTOM: enc_word = {head.funct7, head.rs2, head.rs1, head.funct3, head.rd, OP_CUSTOM};
`endif
            default:    enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i)                  state_d = ST_RUN;
            ST_RUN:   if (push && bus.cmd_last)     state_d = ST_FLUSH;
            // Empty here means the final pop has already been registered
            ST_FLUSH: if (empty)                    state_d = ST_DONE;
            ST_DONE:                                state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE;
            waddr_q <= BASE;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= pop && enc_legal;
            if (pop && enc_legal) begin
                waddr_q <= addr_q;
                wdata_q <= enc_word;
                addr_q  <= addr_q + 1'b1;
                if (addr_q == '1) err_q <= 1'b1;
            end
            if (pop && !enc_legal) err_q <= 1'b1;
            if ((state_q == ST_IDLE) && start_i) begin
                addr_q <= BASE;
                err_q  <= 1'b0;
            end
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);
    assign err_o          = err_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_encoder
// Brief  : Scoreboard bench for instr_encoder with a field-arithmetic model
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_encoder;
    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_i;
    logic busy_o, done_o, err_o;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;
    int                last_wr_cyc = -10;
    int                prev_wr_cyc = -10;
    int                accept_cyc = 0;
    exp_t              sb[$];
    logic [ADDR_W-1:0] exp_addr;
    bit                exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference encoding from the ISA bit positions, using plain arithmetic
    function automatic logic [31:0] ref_enc(input int fmt, rd, rs1, rs2, f3, f7, imm,
                                            output bit ok);
        longint w;
        longint op;
        ok = 1'b1;
        op = 0;
        case (fmt)
            0: op = 'h33;
            1: op = 'h13;
            2: op = 'h03;
            3: op = 'h23;
            4: op = 'h63;
`ifdef INSTR_ENC_CUSTOM_EN
            5: op = 'h2B;
`endif
            default: ok = 1'b0;
        endcase
        w = op + longint'(f3) * (1 << 12) + longint'(rs1) * (1 << 15);
        case (fmt)
            0, 5: w += longint'(rd) * 128 + longint'(rs2) * (1 << 20) + longint'(f7) * (1 << 25);
            1, 2: w += longint'(rd) * 128 + longint'(imm % 4096) * (1 << 20);
            3:    w += longint'(imm % 32) * 128 + longint'(rs2) * (1 << 20)
                     + longint'((imm / 32) % 128) * (1 << 25);
            4:    w += longint'((imm / 2) % 16) * 256 + longint'((imm / 2048) % 2) * 128
                     + longint'(rs2) * (1 << 20) + longint'((imm / 32) % 64) * (1 << 25)
                     + longint'((imm / 4096) % 2) * (longint'(1) << 31);
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.imem_we) begin
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, none expected",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
                chk("imem_wdata", bus.imem_wdata, e.data);
            end
        end
    end

    task automatic start_session();
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        exp_addr = ADDR_W'(BASE_ADDR);
        exp_err  = 1'b0;
    endtask

    task automatic send(input int fmt, rd, rs1, rs2, f3, f7, imm, input bit last,
                        input bit use_lit = 1'b0, input logic [31:0] lit = 32'h0);
        int n;
        bit ok;
        logic [31:0] w;
        n = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_fmt    = 3'(fmt);
        bus.cmd_rd     = 5'(rd);
        bus.cmd_rs1    = 5'(rs1);
        bus.cmd_rs2    = 5'(rs2);
        bus.cmd_funct3 = 3'(f3);
        bus.cmd_funct7 = 7'(f7);
        bus.cmd_imm    = 13'(imm);
        bus.cmd_last   = last;
        while (!bus.cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout: ready %b after %0d cycles, required 1", bus.cmd_ready, n);
            bus.cmd_valid = 1'b0;
        end else begin
            w = ref_enc(fmt, rd, rs1, rs2, f3, f7, imm, ok);
            if (use_lit) w = lit;
            if (ok) begin
                sb.push_back('{exp_addr, w});
                if (exp_addr == '1) exp_err = 1'b1;
                exp_addr = exp_addr + 1'b1;
            end else begin
                exp_err = 1'b1;
            end
            @(posedge clk); #1;
            accept_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input bit chk_lat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        bus.cmd_valid = 1'b0;
        while (n < 300 && !seen) begin
            @(negedge clk);
            n++;
            if (done_o) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done %b after %0d cycles, required 1", done_o, n);
        end else begin
            chk("err_at_done", 32'(err_o), 32'(exp_err));
            chk("sb_drained", 32'(sb.size()), 32'd0);
            chk("busy_at_done", 32'(busy_o), 32'd1);
            if (chk_lat) chk("done_after_we", 32'(cyc), 32'(last_wr_cyc + 1));
            @(negedge clk);
            chk("done_pulse", 32'(done_o), 32'd0);
            chk("busy_after_done", 32'(busy_o), 32'd0);
        end
    endtask

    task automatic rand_cmd(input bit last, input bit legal_only);
        int fmt;
        fmt = legal_only ? $urandom_range(0, 4) : $urandom_range(0, 7);
        send(fmt, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 8191), last);
    endtask

    initial begin
        rst_n          = 1'b0;
        start_i        = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_fmt    = '0;
        bus.cmd_rd     = '0;
        bus.cmd_rs1    = '0;
        bus.cmd_rs2    = '0;
        bus.cmd_funct3 = '0;
        bus.cmd_funct7 = '0;
        bus.cmd_imm    = '0;
        bus.cmd_last   = 1'b0;
        exp_addr       = ADDR_W'(BASE_ADDR);
        exp_err        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'(BASE_ADDR));
        chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // add x3,x1,x2 as a one-command session
        start_session();
        send(0, 3, 1, 2, 0, 0, 0, 1'b1, 1'b1, 32'h002081B3);
        wait_done(1'b1);
        chk("write_latency", 32'(last_wr_cyc), 32'(accept_cyc + 1));

        // addi x1,x0,5 ; lw x5,16(x1) back to back
        start_session();
        send(1, 1, 0, 0, 0, 0, 5, 1'b0, 1'b1, 32'h00500093);
        send(2, 5, 1, 0, 2, 0, 16, 1'b1, 1'b1, 32'h0100A283);
        wait_done(1'b1);
        chk("back_to_back", 32'(last_wr_cyc - prev_wr_cyc), 32'd1);

        // sw x2,8(x1) ; beq x1,x2,-4
        start_session();
        send(3, 0, 1, 2, 2, 0, 8, 1'b0, 1'b1, 32'h0020A423);
        send(4, 0, 1, 2, 0, 0, 13'h1FFC, 1'b1, 1'b1, 32'hFE208EE3);
        wait_done(1'b0);

        // sustained burst deeper than the FIFO
        start_session();
        for (int i = 0; i < 3 * DEPTH; i++) rand_cmd(i == 3 * DEPTH - 1, 1'b1);
        wait_done(1'b0);

        // illegal fmt 7 and fmt 5 mid-stream
        start_session();
        send(1, 1, 0, 0, 0, 0, 1, 1'b0);
        send(7, 1, 2, 3, 0, 0, 0, 1'b0);
        send(1, 2, 0, 0, 0, 0, 2, 1'b0);
        send(5, 4, 5, 6, 1, 7'h21, 0, 1'b0);
        send(1, 3, 0, 0, 0, 0, 3, 1'b1);
        wait_done(1'b0);

        // address wrap past 2^ADDR_W-1
        start_session();
        for (int i = 0; i <= (1 << ADDR_W); i++) rand_cmd(i == (1 << ADDR_W), 1'b1);
        wait_done(1'b0);

        // start outside IDLE must not restart the address counter
        start_session();
        send(1, 1, 0, 0, 0, 0, 9, 1'b0);
        idle(0);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        send(1, 2, 0, 0, 0, 0, 10, 1'b1);
        wait_done(1'b0);

        // randomized sessions with idle gaps and illegal formats
        for (int s = 0; s < 20; s++) begin
            int len;
            len = $urandom_range(1, 20);
            start_session();
            for (int i = 0; i < len; i++) begin
                rand_cmd(i == len - 1, 1'b0);
                if (i != len - 1) idle($urandom_range(0, 2));
            end
            wait_done(1'b0);
        end

        // asynchronous reset in the middle of a session
        start_session();
        send(7, 0, 0, 0, 0, 0, 0, 1'b0);
        send(1, 1, 1, 0, 0, 0, 7, 1'b0);
        bus.cmd_valid = 1'b0;
        chk("err_before_rst", 32'(err_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_imem_we", 32'(bus.imem_we), 32'd0);
        chk("mid_rst_imem_addr", 32'(bus.imem_addr), 32'(BASE_ADDR));
        chk("mid_rst_imem_wdata", bus.imem_wdata, 32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        sb.delete();
        exp_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_done", 32'(done_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
